// File: rtl/drbg_keystream_scheduler.sv
// rtl/drbg_keystream_scheduler.sv - DRBG request sequencer feeding a show-ahead keystream FIFO
// Fetches 256-bit words from the hash DRBG and reseeds/flushes on every frame boundary.
module drbg_keystream_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          master_mode,
  input  logic                          frame_start,
  output logic                          drbg_is_master_mode,
  output logic                          drbg_next_seed,
  output logic                          drbg_next_bits,
  input  logic                          drbg_init_ready,
  input  logic                          drbg_next_bits_ready,
  input  logic [255:0]                  drbg_random_bits,
  output logic                          ks_valid,
  input  logic                          ks_ready,
  output logic [255:0]                  ks_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_WAIT, S_FILL, S_REQ, S_RELEASE, S_RESEED, S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rdy_q;
  logic          pending_q, pending_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;
  logic          master_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [255:0]  mem_q [FIFO_DEPTH];
  logic          rdy_rise, timed_out, push, pop;

  assign rdy_rise  = drbg_next_bits_ready & ~rdy_q;
  assign timed_out = (timer_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable) state_d = S_INIT_WAIT;
      S_INIT_WAIT: begin
        if (drbg_init_ready)  state_d = S_FILL;
        else if (timed_out)   state_d = S_ERROR;
      end
      // A frame_start seen in FILL must not launch a request for the old frame.
      S_FILL: begin
        if (pending_q || frame_start)              state_d = S_RESEED;
        else if (enable && (level_q < DEPTH_L))    state_d = S_REQ;
      end
      S_REQ: begin
        if (rdy_rise)        state_d = S_RELEASE;
        else if (timed_out)  state_d = S_ERROR;
      end
      S_RELEASE:   state_d = S_FILL;
      S_RESEED:    state_d = S_INIT_WAIT;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drbg_next_bits      = (state_q == S_REQ);
    drbg_next_seed      = (state_q == S_RESEED);
    drbg_is_master_mode = master_q;
    timeout_err         = err_q;
    ks_valid            = (level_q != '0);
    ks_data             = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    fifo_level          = level_q;
  end

  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) && ((state_q == S_INIT_WAIT) || (state_q == S_REQ))) begin
      timer_d = timer_q + 1'b1;
    end
    pending_d = pending_q;
    if (frame_start)                pending_d = 1'b1;
    else if (state_q == S_RESEED)   pending_d = 1'b0;
    // The word requested before a flush belongs to the old frame and is discarded.
    drop_d = (state_d == S_REQ) && (drop_q || frame_start);
    err_d  = err_q || (state_d == S_ERROR);
  end

  assign push = (state_q == S_REQ) && rdy_rise && !drop_q && !frame_start;
  assign pop  = (level_q != '0) && ks_ready && !frame_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      rdy_q     <= 1'b0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      err_q     <= 1'b0;
      master_q  <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      rdy_q     <= drbg_next_bits_ready;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
      master_q  <= master_mode;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (frame_start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= drbg_random_bits;
  end

endmodule

// File: tb/tb_drbg_keystream_scheduler.sv
// tb/tb_drbg_keystream_scheduler.sv - self-checking bench for drbg_keystream_scheduler
module tb_drbg_keystream_scheduler;

  localparam int DEPTH = 4;
  localparam int TMO   = 4096;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable, master_mode, frame_start;
  logic         drbg_is_master_mode, drbg_next_seed, drbg_next_bits;
  logic         drbg_init_ready, drbg_next_bits_ready;
  logic [255:0] drbg_random_bits;
  logic         ks_valid, ks_ready;
  logic [255:0] ks_data;
  logic [2:0]   fifo_level;
  logic         timeout_err;

  always #5 clk = ~clk;

  drbg_keystream_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .master_mode         (master_mode),
    .frame_start         (frame_start),
    .drbg_is_master_mode (drbg_is_master_mode),
    .drbg_next_seed      (drbg_next_seed),
    .drbg_next_bits      (drbg_next_bits),
    .drbg_init_ready     (drbg_init_ready),
    .drbg_next_bits_ready(drbg_next_bits_ready),
    .drbg_random_bits    (drbg_random_bits),
    .ks_valid            (ks_valid),
    .ks_ready            (ks_ready),
    .ks_data             (ks_data),
    .fifo_level          (fifo_level),
    .timeout_err         (timeout_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [4:0] in_v;   // enable, master_mode, frame_start, init_ready, ks_ready
    logic [3:0] ex_v;   // next_bits, next_seed, is_master_mode, ks_valid
    logic [2:0] ex_lvl;
  } vec_t;
  vec_t vq[$];

  // Reference model state: DRBG responder plus an ideal word queue.
  bit           model_on;
  bit           fixed_lat;
  int           lat_target, lat_cnt, kr_mode, level_pred, consumed, word_idx;
  logic [255:0] exp_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic         push_n, pop_n;
    logic [255:0] w;
    chk("level", fifo_level, level_pred);
    chk("valid", ks_valid, level_pred != 0);
    push_n = 1'b0;
    if (!drbg_next_bits) begin
      drbg_next_bits_ready = 1'b0;
      lat_cnt = 0;
    end else if (!drbg_next_bits_ready) begin
      lat_cnt++;
      if (lat_cnt >= lat_target) begin
        for (int k = 1; k < 8; k++) w[k*32 +: 32] = $urandom();
        w[31:0] = word_idx;
        word_idx++;
        drbg_random_bits     = w;
        drbg_next_bits_ready = 1'b1;
        push_n = 1'b1;
        exp_q.push_back(w);
        lat_target = fixed_lat ? 10 : $urandom_range(1, 12);
      end
    end
    case (kr_mode)
      0:       ks_ready = 1'b0;
      1:       ks_ready = 1'b1;
      default: ks_ready = 1'($urandom_range(0, 1));
    endcase
    pop_n = ks_valid & ks_ready;
    if (pop_n) begin
      if (exp_q.size() == 0) chk("pop_underrun", 1, 0);
      else begin
        chk("ks_data", ks_data, exp_q.pop_front());
        consumed++;
      end
    end
    level_pred = level_pred + int'(push_n) - int'(pop_n);
    if (push_n) chk("no_overflow", level_pred <= DEPTH, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (model_on) model_step();
  endtask

  task automatic do_reset();
    model_on = 0;
    reset_n = 1'b0;
    enable = 0; master_mode = 0; frame_start = 0; drbg_init_ready = 0;
    drbg_next_bits_ready = 0; drbg_random_bits = '0; ks_ready = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    lat_cnt = 0; level_pred = 0; consumed = 0; exp_q.delete();
  endtask

  task automatic wait_nb(input string name);
    int n = 0;
    while (!drbg_next_bits && n < 50) begin
      tick();
      n++;
    end
    chk(name, drbg_next_bits, 1);
  endtask

  task automatic deliver(input logic [255:0] w, input string name);
    wait_nb(name);
    drbg_random_bits     = w;
    drbg_next_bits_ready = 1'b1;
    tick();
    drbg_next_bits_ready = 1'b0;
  endtask

  task automatic add(input string nm, input logic [4:0] iv, input logic [3:0] ev, input logic [2:0] lv);
    vec_t v;
    v.name = nm; v.in_v = iv; v.ex_v = ev; v.ex_lvl = lv;
    vq.push_back(v);
  endtask

  initial begin
    logic [255:0] w0, w1, w2, w3, w4, w5;
    int n, seeds, nb_seen;
    w0 = {8{32'h1111_0000}}; w1 = {8{32'h2222_0001}}; w2 = {8{32'h3333_0002}};
    w3 = {8{32'h4444_0003}}; w4 = {8{32'h5555_0004}}; w5 = {8{32'h6666_0005}};
    word_idx = 0; fixed_lat = 1; lat_target = 10; kr_mode = 0;

    // Control sequence from IDLE, one clock per row.
    add("idle_master",  5'b01000, 4'b0010, 3'd0);
    add("idle_slave",   5'b00000, 4'b0000, 3'd0);
    add("pop_empty",    5'b10001, 4'b0000, 3'd0);
    add("fs_initwait",  5'b10100, 4'b0000, 3'd0);
    add("fs_twice",     5'b10100, 4'b0000, 3'd0);
    add("to_fill",      5'b10010, 4'b0000, 3'd0);
    add("reseed_pulse", 5'b10010, 4'b0100, 3'd0);
    add("seed_single",  5'b10000, 4'b0000, 3'd0);
    add("fill_again",   5'b10010, 4'b0000, 3'd0);
    add("req_issue",    5'b10010, 4'b1000, 3'd0);
    add("req_hold",     5'b11010, 4'b1010, 3'd0);

    do_reset();
    chk("rst_outputs", {drbg_is_master_mode, drbg_next_seed, drbg_next_bits, ks_valid, timeout_err}, 5'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_data", ks_data, 0);

    foreach (vq[i]) begin
      {enable, master_mode, frame_start, drbg_init_ready, ks_ready} = vq[i].in_v;
      tick();
      chk(vq[i].name, {drbg_next_bits, drbg_next_seed, drbg_is_master_mode, ks_valid}, vq[i].ex_v);
      chk({vq[i].name, "_lvl"}, fifo_level, vq[i].ex_lvl);
    end

    // Push+pop at level 2, then frame_start during REQ.
    do_reset();
    enable = 1; drbg_init_ready = 1;
    deliver(w0, "req_w0");
    deliver(w1, "req_w1");
    tick();
    chk("level_two", fifo_level, 2);
    wait_nb("req_w2");
    drbg_random_bits = w2; drbg_next_bits_ready = 1; ks_ready = 1;
    tick();
    drbg_next_bits_ready = 0; ks_ready = 0;
    chk("pushpop_level", fifo_level, 2);
    chk("pushpop_head", ks_data, w1);

    wait_nb("req_w3");
    frame_start = 1; ks_ready = 1;
    tick();
    chk("flush_level", fifo_level, 0);
    chk("flush_valid", ks_valid, 0);
    tick();
    frame_start = 0; ks_ready = 0;
    chk("flush_still_req", drbg_next_bits, 1);
    drbg_random_bits = w3; drbg_next_bits_ready = 1;
    tick();
    drbg_next_bits_ready = 0;
    chk("dropped_level", fifo_level, 0);
    chk("dropped_release", drbg_next_bits, 0);
    seeds = 0; nb_seen = 0;
    repeat (10) begin
      tick();
      if (drbg_next_seed) begin
        seeds++;
        drbg_init_ready = 0;
      end
      if (drbg_next_bits) nb_seen++;
    end
    chk("one_reseed", seeds, 1);
    repeat (20) begin
      tick();
      if (drbg_next_bits) nb_seen++;
    end
    chk("wait_init_after_seed", nb_seen, 0);
    drbg_init_ready = 1;
    deliver(w4, "refill_req");
    tick();
    chk("refill_level", fifo_level, 1);
    chk("refill_data", ks_data, w4);

    // DRBG never answers: timeout after TMO request cycles.
    wait_nb("tmo_req");
    n = 0;
    while (drbg_next_bits && n < TMO + 100) begin
      n++;
      tick();
    end
    chk("tmo_req_cycles", n, TMO);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_nb_low", drbg_next_bits, 0);
    repeat (5) tick();
    chk("err_no_requests", {drbg_next_bits, drbg_next_seed}, 2'b00);
    chk("err_head", ks_data, w4);
    ks_ready = 1;
    tick();
    ks_ready = 0;
    chk("err_drained", fifo_level, 0);

    // Asynchronous reset in the middle of REQ.
    do_reset();
    enable = 1; drbg_init_ready = 1; master_mode = 1;
    deliver(w5, "ar_w5");
    wait_nb("ar_req");
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_outputs", {drbg_is_master_mode, drbg_next_seed, drbg_next_bits, ks_valid, timeout_err}, 5'b0);
    chk("ar_level", fifo_level, 0);
    chk("ar_data", ks_data, 0);
    #2;
    reset_n = 1'b1;
    master_mode = 0;
    deliver(w0, "ar_resume");
    tick();
    chk("ar_resume_data", ks_data, w0);

    // Fill with no consumer: init_ready at cycle 20, fixed 10-cycle DRBG.
    do_reset();
    fixed_lat = 1; lat_target = 10; kr_mode = 0; enable = 1;
    model_on = 1;
    nb_seen = 0;
    repeat (20) begin
      tick();
      if (drbg_next_bits) nb_seen++;
    end
    chk("no_req_before_init", nb_seen, 0);
    drbg_init_ready = 1;
    n = 0;
    while (fifo_level != 3'(DEPTH) && n < 300) begin
      tick();
      n++;
    end
    chk("fill_full", fifo_level, DEPTH);
    nb_seen = 0;
    repeat (40) begin
      tick();
      if (drbg_next_bits) nb_seen++;
    end
    chk("full_no_req", nb_seen, 0);
    chk("full_words", exp_q.size(), DEPTH);

    // Continuous consumer for 1024 words with random DRBG latency.
    fixed_lat = 0; kr_mode = 1;
    n = 0;
    while (consumed < 1024 && n < 30000) begin
      tick();
      n++;
    end
    chk("stream_1024", consumed >= 1024, 1);

    // Random back-pressure and enable toggling, then drain.
    kr_mode = 2;
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 15) == 0) enable = ~enable;
    end
    enable = 0; kr_mode = 1;
    repeat (60) tick();
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_level", fifo_level, 0);
    model_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
